// File: rtl/dffe_skid_stage.sv
// Purpose : two-entry registered skid stage; turns a valid/ready stream into
//           per-cycle enable (E) and data (Q) for a downstream register bank.
// Latency : 1 cycle from accepted D to Q when the stage is empty or popping.
// Backpr. : in_ready is registered and drops only when both entries are full;
//           no combinational path from out_ready to in_ready.
// Ports   : clk; R sync reset (highest priority); S sync set (loads SET_VAL);
//           in_valid/in_ready/D upstream; out_valid/out_ready/Q downstream;
//           E = out_valid & out_ready.
module dffe_skid_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             R,
  input  logic             S,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             E
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_skid;

  logic             w_acc;
  logic             w_pop;

  // Handshakes are formed only from registered flags, so D is never sampled
  // unless in_valid is high and the stage is actually accepting.
  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (R) begin
      r_state     <= ST_EMPTY;
      r_q         <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (S) begin
      // Preload a known word; any handshake in this cycle is dropped.
      r_state     <= ST_ONE;
      r_q         <= SET_VAL;
      r_skid      <= '0;
      r_out_valid <= 1'b1;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_q         <= D;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            // Full-throughput case: replace the word leaving this cycle.
            r_q <= D;
          end else if (w_acc) begin
            // Downstream stalled: park the new word in the skid register.
            r_skid     <= D;
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can move the state.
          if (w_pop) begin
            r_q        <= r_skid;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Q         = r_q;
  // out_valid is low in EMPTY, so E can never fire there.
  assign E         = r_out_valid & out_ready;

endmodule

// File: tb/tb_dffe_skid_stage.sv
module tb_dffe_skid_stage;

  logic       clk;
  logic       R, S, in_valid, in_ready, out_valid, out_ready, E;
  logic [7:0] D, Q;

  dffe_skid_stage #(.WIDTH(8), .SET_VAL(8'hFF)) dut (
    .clk(clk), .R(R), .S(S),
    .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .E(E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: a depth-2 FIFO of words the stage currently holds.
  logic [7:0] mq[$];
  bit         m_init = 0;

  typedef struct {
    logic       r, s, iv;
    logic [7:0] d;
    logic       ordy;
    logic       eov, eir;
    logic [7:0] eq;
    logic       ee;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic addv(input logic r, s, iv, input logic [7:0] d, input logic ordy,
                      input logic eov, eir, input logic [7:0] eq, input logic ee);
    vec_t v;
    v.r = r; v.s = s; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eir = eir; v.eq = eq; v.ee = ee;
    tbl.push_back(v);
  endtask

  // Drive one cycle: compare DUT against the reference mid-cycle, then
  // advance the reference at the edge.
  task automatic cyc(input logic r, s, iv, input logic [7:0] d, input logic ordy);
    bit acc, pop;
    R = r; S = s; in_valid = iv; D = d; out_ready = ordy;
    @(negedge clk);
    if (m_init) begin
      check("sb_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      check("sb_in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < 2});
      check("sb_E",         {31'd0, E},         {31'd0, (mq.size() > 0) && ordy});
      if (mq.size() > 0) check("sb_Q_order", {24'd0, Q}, {24'd0, mq[0]});
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_init = 1;
    end else if (s) begin
      mq.delete();
      mq.push_back(8'hFF);
    end else begin
      acc = iv && (mq.size() < 2);
      pop = (mq.size() > 0) && ordy;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    #1;
  endtask

  initial begin
    R = 1; S = 0; in_valid = 0; D = 0; out_ready = 0;

    //    R  S  iv D      rdy  ov ir Q      E
    addv(1, 0, 0, 8'h00, 0,   0, 1, 8'h00, 0);    // reset state
    for (int i = 1; i <= 8; i++)                  // streaming, one per cycle
      addv(0, 0, 1, 8'(i), 1, 1, 1, 8'(i), 1);
    addv(0, 0, 0, 8'h00, 1,   0, 1, 8'h08, 0);    // drain
    addv(0, 0, 1, 8'hA1, 0,   1, 1, 8'hA1, 0);    // backpressure
    addv(0, 0, 1, 8'hA2, 0,   1, 0, 8'hA1, 0);    // -> TWO
    addv(0, 0, 1, 8'hA3, 0,   1, 0, 8'hA1, 0);    // ignored while full
    addv(0, 0, 1, 8'hA3, 1,   1, 1, 8'hA2, 1);    // pop skid
    addv(0, 0, 1, 8'hA3, 1,   1, 1, 8'hA3, 1);    // accept A3 while popping
    addv(0, 0, 0, 8'h00, 1,   0, 1, 8'hA3, 0);    // drain
    addv(0, 1, 1, 8'h55, 0,   1, 1, 8'hFF, 0);    // set beats accept
    addv(0, 0, 0, 8'h00, 1,   0, 1, 8'hFF, 0);    // 0x55 was discarded
    addv(1, 1, 1, 8'h66, 0,   0, 1, 8'h00, 0);    // reset beats set
    addv(0, 0, 1, 8'hB1, 0,   1, 1, 8'hB1, 0);
    addv(0, 0, 1, 8'hB2, 0,   1, 0, 8'hB1, 0);    // TWO
    addv(1, 0, 0, 8'h00, 0,   0, 1, 8'h00, 0);    // reset in TWO
    addv(0, 0, 0, 8'h00, 1,   0, 1, 8'h00, 0);    // skid word not emitted
    addv(0, 0, 1, 8'hC1, 1,   1, 1, 8'hC1, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].eov});
      check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].eir});
      check($sformatf("vec%0d_Q", i),         {24'd0, Q},         {24'd0, tbl[i].eq});
      check($sformatf("vec%0d_E", i),         {31'd0, E},         {31'd0, tbl[i].ee});
    end

    // Random traffic against the scoreboard.
    for (int n = 0; n < 10000; n++) begin
      logic rr, ss, iv, ordy;
      logic [7:0] dd;
      rr   = ($urandom_range(0, 299) == 0);
      ss   = ($urandom_range(0, 199) == 0);
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 50);
      dd   = 8'($urandom);
      cyc(rr, ss, iv, dd, ordy);
    end
    cyc(0, 0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
